// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, taken-branch flushes and data-memory waits.
// Optional performance counters are built when the PERF_CNT_EN macro is defined.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_mem_branch_taken,
  input  logic             ex_mem_mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       fsm_state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    SHADOW   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   mem_wait, branch_flush, load_use, rd_match;

  assign fsm_state = state;
  assign rd_match  = (id_ex_rd != 5'd0) &&
                     ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  // EX/MEM stays frozen during a wait, so MEM_WAIT keeps waiting until ready
  // even if the access flag is not re-presented.
  always_comb begin
    mem_wait     = 1'b0;
    branch_flush = 1'b0;
    load_use     = 1'b0;
    state_nxt    = RUN;
    if (!reset) begin
      mem_wait     = !dmem_ready && (ex_mem_mem_access || (state == MEM_WAIT));
      branch_flush = ex_mem_branch_taken && !mem_wait;
      load_use     = id_ex_mem_read && rd_match && !mem_wait && !branch_flush &&
                     (state != SHADOW);
      if (mem_wait)          state_nxt = MEM_WAIT;
      else if (branch_flush) state_nxt = SHADOW;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    mem_wb_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (mem_wait) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_flush) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

`ifdef PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (load_use && (stall_cnt != '1))       stall_cnt   <= stall_cnt + 1'b1;
      if (branch_flush && (flush_cnt != '1))   flush_cnt   <= flush_cnt + 1'b1;
      if (mem_wait && (memwait_cnt != '1))     memwait_cnt <= memwait_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl with a queue-based scoreboard.
// Counter checks are compiled in when PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       clk, reset;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       id_ex_mem_read, ex_mem_branch_taken, ex_mem_mem_access, dmem_ready;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic       if_id_flush, id_ex_bubble, ex_mem_flush, mem_wb_bubble;
  logic [1:0] fsm_state;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_branch_taken(ex_mem_branch_taken), .ex_mem_mem_access(ex_mem_mem_access),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble),
    .fsm_state(fsm_state)
`ifdef PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8:0] DEFAULTS = 9'b11111_0000;

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the previous cycle's event decides where we are now.
  bit m_prev_wait, m_prev_flush;
  bit p_stall, p_flush, p_wait;
  int m_stall, m_flush, m_wait;

  function automatic logic [8:0] out_vec();
    return {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
            if_id_flush, id_ex_bubble, ex_mem_flush, mem_wb_bubble};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev_wait = 0; m_prev_flush = 0;
    p_stall = 0; p_flush = 0; p_wait = 0;
    m_stall = 0; m_flush = 0; m_wait = 0;
  endtask

  task automatic set_idle();
    if_id_rs1 = 0; if_id_rs2 = 0; id_ex_rd = 0; id_ex_mem_read = 0;
    ex_mem_branch_taken = 0; ex_mem_mem_access = 0; dmem_ready = 1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic bt, input logic acc, input logic rdy);
    bit waiting, flush, hazard, stall;
    @(posedge clk); #2;
    if (p_stall && m_stall < CMAX) m_stall++;
    if (p_flush && m_flush < CMAX) m_flush++;
    if (p_wait  && m_wait  < CMAX) m_wait++;
    if_id_rs1 = rs1; if_id_rs2 = rs2; id_ex_rd = rd; id_ex_mem_read = mr;
    ex_mem_branch_taken = bt; ex_mem_mem_access = acc; dmem_ready = rdy;
    waiting = !rdy && (acc || m_prev_wait);
    flush   = bt && !waiting;
    hazard  = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    stall   = hazard && !waiting && !flush && !m_prev_flush;
    exp_q.push_back({!waiting && !stall, !waiting && !stall, !waiting, !waiting, 1'b1,
                     flush, flush || stall, flush, waiting});
    p_stall = stall; p_flush = flush; p_wait = waiting;
    m_prev_wait = waiting; m_prev_flush = flush;
  endtask

  task automatic check_cnt();
`ifdef PERF_CNT_EN
    check("stall_cnt",   int'(stall_cnt),   m_stall);
    check("flush_cnt",   int'(flush_cnt),   m_flush);
    check("memwait_cnt", int'(memwait_cnt), m_wait);
`endif
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (out_vec() !== e) begin
        n_fail++;
        $display("FAIL outputs: got %b expected %b at %0t", out_vec(), e, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    reset = 1'b1;
    if_id_rs1 = 5; if_id_rs2 = 5; id_ex_rd = 5; id_ex_mem_read = 1;
    ex_mem_branch_taken = 1; ex_mem_mem_access = 1; dmem_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'(out_vec()), int'(DEFAULTS));
    check_cnt();
    set_idle();
    @(negedge clk); reset = 1'b0;

    // load-use on rs2, then hazard cleared
    drive(0, 5, 5, 1, 0, 0, 1);
    drive(0, 5, 5, 0, 0, 0, 1);
    check_cnt();
    // x0 load never stalls
    drive(0, 3, 0, 1, 0, 0, 1);
    // branch, load-use in shadow suppressed, then RUN stalls again
    drive(1, 2, 0, 0, 1, 0, 1);
    drive(7, 0, 7, 1, 0, 0, 1);
    drive(7, 0, 7, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_cnt();
    // three-cycle memory wait then ready
    repeat (3) drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_cnt();
    // all three events together: freeze, then flush without stall
    drive(4, 4, 4, 1, 1, 1, 0);
    drive(4, 4, 4, 1, 1, 1, 0);
    drive(4, 4, 4, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_cnt();

    // randomised traffic, small register range to provoke hazards
    for (int i = 0; i < 300; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
      if (i % 50 == 49) check_cnt();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    check_cnt();

    // saturation: 20 load-use cycles
    for (int i = 0; i < 20; i++) drive(5, 0, 5, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_cnt();
`ifdef PERF_CNT_EN
    check("stall_cnt_saturated", int'(stall_cnt), CMAX);
`endif

    // asynchronous reset in the middle of a memory wait
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("reset_midwait_outputs", int'(out_vec()), int'(DEFAULTS));
`ifdef PERF_CNT_EN
    check("reset_stall_cnt",   int'(stall_cnt),   0);
    check("reset_flush_cnt",   int'(flush_cnt),   0);
    check("reset_memwait_cnt", int'(memwait_cnt), 0);
`endif
    set_idle();
    model_reset();
    @(negedge clk); reset = 1'b0;
    drive(0, 6, 6, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_cnt();

    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
